// File: rtl/pe_acc_if.sv
// Bus bundle between the multiplier-side controller and one PE accumulator.
interface pe_acc_if #(
  parameter int unsigned MUL_W = 32,
  parameter int unsigned ACC_W = 40
);
  logic             i_en_ff;
  logic [MUL_W-1:0] i_prod;
  logic             i_valid;
  logic             i_start;
  logic             i_swap;
  logic             i_shift_en;
  logic [ACC_W-1:0] i_cshift;
  logic [ACC_W-1:0] o_cshift;
  logic [ACC_W-1:0] o_acc;
  logic             o_ovf;

  modport master (
    output i_en_ff, i_prod, i_valid, i_start, i_swap, i_shift_en, i_cshift,
    input  o_cshift, o_acc, o_ovf
  );

  modport slave (
    input  i_en_ff, i_prod, i_valid, i_start, i_swap, i_shift_en, i_cshift,
    output o_cshift, o_acc, o_ovf
  );
endinterface

// File: rtl/pe_accumulator.sv
// Per-PE accumulation stage: sums multiplier products with optional saturation
// and parks finished sums in a shadow register on the column shift chain.
module pe_accumulator #(
  parameter int unsigned STAGES = 0,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned MUL_W  = 32,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned SAT    = 0
) (
  input logic   i_clk,
  input logic   i_rstn,
  pe_acc_if.slave bus
);

  localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] U_MAX = '1;

  logic             v_d;
  logic             s_d;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] shadow;
  logic             ovf;
  logic [ACC_W-1:0] ext_c;
  logic [ACC_W:0]   sum_c;
  logic             ovf_c;
  logic [ACC_W-1:0] sat_c;
  logic [ACC_W-1:0] acc_nxt;
  logic             ovf_nxt;
  logic [ACC_W-1:0] shadow_nxt;

  // Control flags delayed to line up with the multiplier output
  generate
    if (STAGES == 0) begin : g_nodly
      assign v_d = bus.i_valid;
      assign s_d = bus.i_start;
    end else begin : g_dly
      logic [STAGES-1:0] v_pipe;
      logic [STAGES-1:0] s_pipe;

      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
          v_pipe <= '0;
          s_pipe <= '0;
        end else if (bus.i_en_ff) begin
          v_pipe[0] <= bus.i_valid;
          s_pipe[0] <= bus.i_start;
          for (int unsigned i = 1; i < STAGES; i++) begin
            v_pipe[i] <= v_pipe[i-1];
            s_pipe[i] <= s_pipe[i-1];
          end
        end
      end

      assign v_d = v_pipe[STAGES-1];
      assign s_d = s_pipe[STAGES-1];
    end
  endgenerate

  assign ext_c = (SIGNED != 0) ? ACC_W'(signed'(bus.i_prod)) : ACC_W'(bus.i_prod);
  assign sum_c = {1'b0, acc} + {1'b0, ext_c};

  // Signed overflow: like-signed operands producing an opposite-signed sum
  assign ovf_c = (SIGNED != 0)
               ? ((acc[ACC_W-1] == ext_c[ACC_W-1]) && (sum_c[ACC_W-1] != acc[ACC_W-1]))
               : sum_c[ACC_W];

  // Clamp direction follows the sign shared by both operands
  assign sat_c = (SIGNED != 0) ? (acc[ACC_W-1] ? S_MIN : S_MAX) : U_MAX;

  always_comb begin
    acc_nxt    = acc;
    ovf_nxt    = ovf;
    shadow_nxt = shadow;
    if (s_d) begin
      acc_nxt = v_d ? ext_c : '0;
      ovf_nxt = 1'b0;
    end else if (v_d) begin
      acc_nxt = sum_c[ACC_W-1:0];
      if (ovf_c) begin
        ovf_nxt = 1'b1;
        if (SAT != 0) acc_nxt = sat_c;
      end
    end
    if (bus.i_swap) begin
      shadow_nxt = acc;
    end else if (bus.i_shift_en) begin
      shadow_nxt = bus.i_cshift;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      acc    <= '0;
      ovf    <= 1'b0;
      shadow <= '0;
    end else if (bus.i_en_ff) begin
      acc    <= acc_nxt;
      ovf    <= ovf_nxt;
      shadow <= shadow_nxt;
    end
  end

  assign bus.o_acc    = acc;
  assign bus.o_ovf    = ovf;
  assign bus.o_cshift = shadow;

endmodule

// File: tb/tb_pe_accumulator.sv
// Self-checking bench: three accumulator configurations, directed vector table,
// multi-cycle reset sequences and randomized traffic against an arithmetic model.
module tb_pe_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-instance configuration: 0 = unsigned wrap, 1 = signed saturate, 2 = unsigned wrap 8b
  int stg[3] = '{2, 0, 1};
  int sgn[3] = '{0, 1, 0};
  int sat[3] = '{0, 1, 0};
  int aw[3]  = '{24, 8, 8};
  int mw[3]  = '{16, 8, 8};

  bit     en[3], v[3], s[3], swp[3], sh[3];
  longint prod[3], csh[3];

  pe_acc_if #(.MUL_W(16), .ACC_W(24)) b0 ();
  pe_acc_if #(.MUL_W(8),  .ACC_W(8))  b1 ();
  pe_acc_if #(.MUL_W(8),  .ACC_W(8))  b2 ();

  assign b0.i_en_ff = en[0];  assign b0.i_prod = 16'(prod[0]); assign b0.i_valid = v[0];
  assign b0.i_start = s[0];   assign b0.i_swap = swp[0];       assign b0.i_shift_en = sh[0];
  assign b0.i_cshift = 24'(csh[0]);
  assign b1.i_en_ff = en[1];  assign b1.i_prod = 8'(prod[1]);  assign b1.i_valid = v[1];
  assign b1.i_start = s[1];   assign b1.i_swap = swp[1];       assign b1.i_shift_en = sh[1];
  assign b1.i_cshift = 8'(csh[1]);
  assign b2.i_en_ff = en[2];  assign b2.i_prod = 8'(prod[2]);  assign b2.i_valid = v[2];
  assign b2.i_start = s[2];   assign b2.i_swap = swp[2];       assign b2.i_shift_en = sh[2];
  assign b2.i_cshift = 8'(csh[2]);

  pe_accumulator #(.STAGES(2), .SIGNED(0), .MUL_W(16), .ACC_W(24), .SAT(0))
    u0 (.i_clk(clk), .i_rstn(rst_n), .bus(b0));
  pe_accumulator #(.STAGES(0), .SIGNED(1), .MUL_W(8), .ACC_W(8), .SAT(1))
    u1 (.i_clk(clk), .i_rstn(rst_n), .bus(b1));
  pe_accumulator #(.STAGES(1), .SIGNED(0), .MUL_W(8), .ACC_W(8), .SAT(0))
    u2 (.i_clk(clk), .i_rstn(rst_n), .bus(b2));

  // Reference model: accumulator held as a mathematical integer, flags history as a list
  longint macc[3], mshd[3];
  bit     movf[3];
  bit     hv[3][4], hs[3][4];

  function automatic longint mask(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  function automatic longint sval(input longint b, input int w, input int sg);
    longint x;
    x = b & mask(w);
    if (sg != 0 && x[w-1]) return x - (longint'(1) << w);
    return x;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      macc[d] = 0; mshd[d] = 0; movf[d] = 1'b0;
      for (int k = 0; k < 4; k++) begin hv[d][k] = 1'b0; hs[d][k] = 1'b0; end
    end
  endtask

  task automatic model_step(input int d);
    longint ext, pre, sum, lo, hi;
    bit vd, sd;
    if (!en[d]) return;
    vd  = (stg[d] == 0) ? v[d] : hv[d][stg[d]-1];
    sd  = (stg[d] == 0) ? s[d] : hs[d][stg[d]-1];
    ext = sval(prod[d], mw[d], sgn[d]);
    pre = macc[d];
    lo  = (sgn[d] != 0) ? -(longint'(1) << (aw[d]-1)) : 0;
    hi  = (sgn[d] != 0) ? (longint'(1) << (aw[d]-1)) - 1 : mask(aw[d]);
    if (sd) begin
      macc[d] = vd ? ext : 0;
      movf[d] = 1'b0;
    end else if (vd) begin
      sum = macc[d] + ext;
      if (sum > hi || sum < lo) begin
        movf[d] = 1'b1;
        if (sat[d] != 0) macc[d] = (sum > hi) ? hi : lo;
        else             macc[d] = sval(sum, aw[d], sgn[d]);
      end else begin
        macc[d] = sum;
      end
    end
    if (swp[d])     mshd[d] = pre & mask(aw[d]);
    else if (sh[d]) mshd[d] = csh[d] & mask(aw[d]);
    for (int k = 3; k > 0; k--) begin hv[d][k] = hv[d][k-1]; hs[d][k] = hs[d][k-1]; end
    hv[d][0] = v[d];
    hs[d][0] = s[d];
  endtask

  task automatic check_dut(input int d, input longint ea, input longint ec, input bit eo,
                           input string nm);
    longint ga, gc;
    bit go;
    case (d)
      0: begin ga = longint'(b0.o_acc); gc = longint'(b0.o_cshift); go = b0.o_ovf; end
      1: begin ga = longint'(b1.o_acc); gc = longint'(b1.o_cshift); go = b1.o_ovf; end
      default: begin ga = longint'(b2.o_acc); gc = longint'(b2.o_cshift); go = b2.o_ovf; end
    endcase
    checks += 3;
    if (ga != ea) begin
      errors++;
      $display("FAIL %s dut%0d o_acc got %0h expected %0h at %0t", nm, d, ga, ea, $time);
    end
    if (gc != ec) begin
      errors++;
      $display("FAIL %s dut%0d o_cshift got %0h expected %0h at %0t", nm, d, gc, ec, $time);
    end
    if (go != eo) begin
      errors++;
      $display("FAIL %s dut%0d o_ovf got %0b expected %0b at %0t", nm, d, go, eo, $time);
    end
  endtask

  task automatic check_model(input int d, input string nm);
    check_dut(d, macc[d] & mask(aw[d]), mshd[d], movf[d], nm);
  endtask

  task automatic set_idle(input bit e);
    for (int d = 0; d < 3; d++) begin
      en[d] = e; v[d] = 1'b0; s[d] = 1'b0; swp[d] = 1'b0; sh[d] = 1'b0;
      prod[d] = 0; csh[d] = 0;
    end
  endtask

  // One clock: inputs already applied; sample #1 after the edge and advance the model
  task automatic cycle();
    @(posedge clk);
    #1;
    if (rst_n) for (int d = 0; d < 3; d++) model_step(d);
  endtask

  typedef struct {
    int     d;
    bit     en, v, s, swp, sh;
    longint prod, csh, ea, ec;
    bit     eo;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int d, input bit e, input bit vv, input bit ss, input bit sw,
                     input bit shf, input longint p, input longint c, input longint ea,
                     input longint ec, input bit eo);
    vec_t r;
    r.d = d; r.en = e; r.v = vv; r.s = ss; r.swp = sw; r.sh = shf;
    r.prod = p; r.csh = c; r.ea = ea; r.ec = ec; r.eo = eo;
    tbl.push_back(r);
  endtask

  initial begin
    // dut0: STAGES=2 unsigned; products 3,5,7, swap+accumulate, stall, shift, swap-vs-shift
    add(0, 1, 1, 1, 0, 0,     0,     0,  0,    0, 0);
    add(0, 1, 1, 0, 0, 0,     0,     0,  0,    0, 0);
    add(0, 1, 1, 0, 0, 0,     3,     0,  3,    0, 0);
    add(0, 1, 0, 0, 0, 0,     5,     0,  8,    0, 0);
    add(0, 1, 1, 0, 0, 0,     7,     0, 15,    0, 0);
    add(0, 1, 0, 0, 0, 0,    99,     0, 15,    0, 0);
    add(0, 1, 0, 0, 1, 0,     4,     0, 19,   15, 0);
    add(0, 0, 1, 0, 0, 0,    50,     0, 19,   15, 0);
    add(0, 0, 1, 0, 0, 0,    50,     0, 19,   15, 0);
    add(0, 0, 1, 0, 0, 0,    50,     0, 19,   15, 0);
    add(0, 1, 0, 0, 0, 1,     0, 'h2A, 19, 'h2A, 0);
    add(0, 1, 0, 0, 1, 1,     0, 'h55, 19,   19, 0);
    // dut1: STAGES=0 signed saturating 8b
    add(1, 1, 1, 1, 0, 0,   100,     0, 100,   0, 0);
    add(1, 1, 1, 0, 0, 0,   100,     0, 127,   0, 1);
    add(1, 1, 1, 1, 0, 0,     2,     0,   2,   0, 0);
    add(1, 1, 1, 0, 0, 0, 'h9C,      0, 'h9E,  0, 0);
    add(1, 1, 1, 0, 0, 0, 'h9C,      0, 'h80,  0, 1);
    add(1, 1, 0, 1, 0, 0,    55,     0,   0,   0, 0);
    // dut2: STAGES=1 unsigned wrapping 8b
    add(2, 1, 1, 1, 0, 0,     0,     0,   0,   0, 0);
    add(2, 1, 1, 0, 0, 0,   200,     0, 200,   0, 0);
    add(2, 1, 0, 0, 0, 0,   100,     0,  44,   0, 1);
    add(2, 1, 0, 0, 0, 0,    55,     0,  44,   0, 1);

    // Reset with non-zero product on the bus
    set_idle(1'b1);
    for (int d = 0; d < 3; d++) prod[d] = 'hFFFF;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check_dut(d, 0, 0, 1'b0, "reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      for (int d = 0; d < 3; d++) check_dut(d, 0, 0, 1'b0, "idle");
    end

    // Directed vectors; untargeted instances are stalled
    foreach (tbl[i]) begin
      set_idle(1'b0);
      en[tbl[i].d]   = tbl[i].en;   v[tbl[i].d]    = tbl[i].v;
      s[tbl[i].d]    = tbl[i].s;    swp[tbl[i].d]  = tbl[i].swp;
      sh[tbl[i].d]   = tbl[i].sh;   prod[tbl[i].d] = tbl[i].prod;
      csh[tbl[i].d]  = tbl[i].csh;
      cycle();
      check_dut(tbl[i].d, tbl[i].ea, tbl[i].ec, tbl[i].eo, $sformatf("vec%0d", i));
    end
    // Model stayed in lock-step through the table
    for (int d = 0; d < 3; d++) check_model(d, "post_vec");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      for (int d = 0; d < 3; d++) begin
        en[d]   = ($urandom_range(9) != 0);
        v[d]    = ($urandom_range(9) < 7);
        s[d]    = ($urandom_range(19) < 3);
        swp[d]  = ($urandom_range(9) == 0);
        sh[d]   = ($urandom_range(9) < 3);
        prod[d] = longint'($urandom) & mask(mw[d]);
        csh[d]  = longint'($urandom) & mask(aw[d]);
      end
      cycle();
      for (int d = 0; d < 3; d++) check_model(d, "rand");
    end

    // Reset mid-accumulation with valid flags still in the delay line
    set_idle(1'b1);
    for (int d = 0; d < 3; d++) begin v[d] = 1'b1; s[d] = 1'b1; prod[d] = 9; end
    cycle();
    for (int d = 0; d < 3; d++) s[d] = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b0;
    model_reset();
    #2;
    for (int d = 0; d < 3; d++) check_dut(d, 0, 0, 1'b0, "midreset");
    for (int d = 0; d < 3; d++) v[d] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      for (int d = 0; d < 3; d++) check_dut(d, 0, 0, 1'b0, "post_reset");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
